mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Owns the single byte-wide RAM port and shares it between two requesters: instruction fetch (IF) and the store/load buffer (LS).
- Grants one requester at a time and sequences each 1/2/4-byte access as consecutive byte cycles.
- Assembles read bytes little-endian, returns them zero-extended with a one-cycle ready pulse. Sign extension stays in the LS unit.
- Sits between the IF unit, the store/load buffer and the top-level RAM/IO interface.

Parameters:
- ADDR_W, 32, byte address width.
- IO_HI, 2'b11, value of addr[17:16] that marks memory-mapped IO.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- rdy  in  1  global enable; low freezes all state
- clear  in  1  pipeline flush (mispredict)
- if_req  in  1  fetch request, level, held until if_ready
- if_addr  in  32  fetch address
- if_ready  out  1  one-cycle pulse: if_data valid
- if_data  out  32  fetched word
- ls_load  in  1  load request, level, held until ls_ready
- ls_store  in  1  store request, level, held until ls_ready
- ls_size  in  2  0=byte, 1=half, 2=word; 3 is treated as word
- ls_addr  in  32  access address
- ls_wdata  in  32  store data, low bytes used
- ls_ready  out  1  one-cycle pulse: load data valid or store done
- ls_rdata  out  32  load data, zero-extended
- mem_din  in  8  RAM read byte, valid the cycle after its address
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  RAM write strobe, 1=write
- io_buffer_full  in  1  IO sink cannot accept a write

Behaviour:
- Reset: state=IDLE. All outputs are 0: if_ready, ls_ready, if_data, ls_rdata, mem_a, mem_dout, mem_wr.
- rdy low:
  - All registers hold.
  - mem_wr is gated to 0 combinationally.
  - Ready pulses are held off and resume when rdy returns.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE arbitration, evaluated each cycle:
  - LS has fixed priority over IF.
  - ls_store -> WRITE; else ls_load -> READ; else if_req -> READ with size=word.
  - On grant, latch base address, size (N = 1/2/4 bytes), write data and owner. Byte counter k=0.
  - No grant while clear=1.
- READ:
  - Byte k is addressed in cycle c1+k; its data is captured at the end of cycle c2+k.
  - After the last byte, go to DONE.
  - Owner's ready pulses in the DONE cycle, so latency from the IDLE acceptance cycle c0 is N+2 cycles (word fetch: 6).
- WRITE:
  - Byte k: mem_a=base+k, mem_dout=wdata[8k+7:8k], mem_wr=1 in cycle c1+k.
  - IO stall: if addr[17:16]==IO_HI and io_buffer_full=1, that cycle has mem_wr=0 and k holds.
  - After the last byte, go to DONE. Unstalled ready arrives at N+1 cycles after c0.
- DONE:
  - Exactly one of if_ready/ls_ready is high; data output is valid.
  - Next state is IDLE. No new grant in this cycle, which prevents double-accept of a still-high request.
- Outside ready pulses, if_data/ls_rdata hold their last value. mem_a returns to 0 and mem_wr to 0 in IDLE.
- Address arithmetic is base+k modulo 2^32 with no alignment check. Unaligned and wrap-around accesses are legal.
- clear:
  - In READ (either owner): abort immediately, go to IDLE next cycle, no ready pulse, partial data discarded.
  - In WRITE: ignored. Committed stores always complete and pulse ls_ready.
  - In DONE: the pulse is suppressed.
- Simultaneous ls_load and ls_store is illegal. If it occurs, store wins.
- Reset (rst=0) mid-access: immediate return to reset values, regardless of rdy.

Decomposition:
- Shared package:
  - state enum (IDLE/READ/WRITE/DONE)
  - size codes (SZ_B=0, SZ_H=1, SZ_W=2)
  - owner codes (OWN_IF, OWN_LS)
  - IO_HI constant
- One natural sub-module, mem_byte_lane: combinational write-byte select from (wdata, k) and read-byte insert into an assembly register, zero-filling bytes ≥N.

Test Plan:
- if_req=1, if_addr=0x100, RAM bytes 0x13,0x05,0x00,0x00 -> mem_a 0x100..0x103 in consecutive cycles; if_ready pulses once 6 cycles after acceptance with if_data=0x00000513.
- if_req and ls_load (size=byte, addr=0x1003, RAM=0xF0) asserted together -> LS served first: ls_rdata=0x000000F0 at +3; then IF served with its own 6-cycle latency.
- ls_store, size=half, addr=0x2000, wdata=0xDEADBEEF -> mem_wr high two cycles: (0x2000,0xEF), (0x2001,0xBE); ls_ready at +3.
- IF word fetch, clear=1 in the second READ cycle -> no if_ready; state IDLE next cycle. Repeat with a word store and clear -> all 4 writes occur and ls_ready pulses.
- Store byte to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr=0 during stall, then a single write of 0x30000; ls_ready at +5.
- rdy low for 2 cycles mid word-read -> mem_wr stays 0, mem_a holds; correct data on resume with latency extended by 2.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Purpose  : Shared types and constants for the byte-wide RAM port arbiter.
// Revision : 1.0
// ============================================================================
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [1:0] IO_HI_DFLT = 2'b11;

    // Size code 3 is folded onto word.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    size_bytes = 3'd1;
            SZ_H:    size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_byte_lane.sv
`default_nettype none
// ============================================================================
// Module   : mem_byte_lane
// Purpose  : Write-byte select and read-byte insert with zero fill above N.
// Revision : 1.0
// ============================================================================
module mem_byte_lane
    import mem_arbiter_pkg::*;
(
    input  logic [31:0] wdata_i,
    input  logic [1:0]  wsel_i,
    input  logic [31:0] asm_i,
    input  logic [7:0]  din_i,
    input  logic [1:0]  isel_i,
    input  logic [2:0]  nbytes_i,
    output logic [7:0]  wbyte_o,
    output logic [31:0] asm_o
);

    assign wbyte_o = 8'(wdata_i >> {wsel_i, 3'b000});

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign asm_o[8*i +: 8] = (3'(i) >= nbytes_i) ? 8'h00 :
                                 (isel_i == 2'(i))   ? din_i : asm_i[8*i +: 8];
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one byte-wide RAM port between fetch (IF) and load/store.
// Revision : 1.0
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = IO_HI_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_data,
    input  logic              ls_load,
    input  logic              ls_store,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_ready,
    output logic [31:0]       ls_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        n_q, n_d;
    logic [2:0]        k_q, k_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;

    logic [ADDR_W-1:0] w_addr;
    logic              w_stall;
    logic [1:0]        w_isel;
    logic [7:0]        w_wbyte;
    logic [31:0]       w_asm_ins;

    assign w_addr  = base_q + ADDR_W'(k_q);
    assign w_stall = (w_addr[17:16] == IO_HI) && io_buffer_full;
    // In READ, cycle k captures the byte addressed one cycle earlier.
    assign w_isel  = k_q[1:0] - 2'd1;

    mem_byte_lane u_lane (
        .wdata_i  (wdata_q),
        .wsel_i   (k_q[1:0]),
        .asm_i    (asm_q),
        .din_i    (mem_din),
        .isel_i   (w_isel),
        .nbytes_i (n_q),
        .wbyte_o  (w_wbyte),
        .asm_o    (w_asm_ins)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            wr_q       <= 1'b0;
            base_q     <= '0;
            n_q        <= '0;
            k_q        <= '0;
            wdata_q    <= '0;
            asm_q      <= '0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wr_q       <= wr_d;
            base_q     <= base_d;
            n_q        <= n_d;
            k_q        <= k_d;
            wdata_q    <= wdata_d;
            asm_q      <= asm_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wr_d       = wr_q;
        base_d     = base_q;
        n_d        = n_q;
        k_d        = k_q;
        wdata_d    = wdata_q;
        asm_d      = asm_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        case (state_q)
            ST_IDLE: begin
                k_d = '0;
                if (!clear) begin
                    if (ls_store || ls_load) begin
                        state_d = ls_store ? ST_WRITE : ST_READ;
                        owner_d = OWN_LS;
                        wr_d    = ls_store;
                        base_d  = ls_addr;
                        n_d     = size_bytes(ls_size);
                        wdata_d = ls_wdata;
                        asm_d   = '0;
                    end else if (if_req) begin
                        state_d = ST_READ;
                        owner_d = OWN_IF;
                        wr_d    = 1'b0;
                        base_d  = if_addr;
                        n_d     = 3'd4;
                        asm_d   = '0;
                    end
                end
            end
            ST_READ: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end else begin
                    if (k_q != 3'd0) begin
                        asm_d = w_asm_ins;
                    end
                    if (k_q == n_q) begin
                        state_d = ST_DONE;
                        if (owner_q == OWN_LS) begin
                            ls_rdata_d = w_asm_ins;
                        end else begin
                            if_data_d = w_asm_ins;
                        end
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end
            end
            ST_WRITE: begin
                if (!w_stall) begin
                    if (k_q == n_q - 3'd1) begin
                        state_d = ST_DONE;
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                k_d     = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        if_ready = 1'b0;
        ls_ready = 1'b0;
        case (state_q)
            ST_READ: mem_a = w_addr;
            ST_WRITE: begin
                mem_a    = w_addr;
                mem_dout = w_wbyte;
                mem_wr   = rdy && !w_stall;
            end
            ST_DONE: begin
                // A flush drops a read result but never a committed store.
                if (rdy && (wr_q || !clear)) begin
                    if (owner_q == OWN_LS) begin
                        ls_ready = 1'b1;
                    end else begin
                        if_ready = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign if_data  = if_data_q;
    assign ls_rdata = ls_rdata_q;

endmodule
`default_nettype wire
